// File: rtl/voice_allocator_if.sv
// Event and voice-update bus of voice_allocator.
//   Event side  : i_evt_valid / o_evt_ready handshake with note_on, note,
//                 velocity and tuning_code payload.
//   Voice side  : o_voice_valid strobe with index, status, tuning, velocity
//                 and dds/adsr flags; o_steal / o_drop pulses; active count.
//   Debug       : o_dbg_state mirrors the allocator FSM state.
// Handshake: an event transfers on a rising clock edge where both
// i_evt_valid and o_evt_ready are 1. The payload must be stable while
// i_evt_valid is high. o_voice_valid is a one-cycle strobe with no
// back-pressure; the voice payload is meaningful only while it is high.
interface voice_allocator_if;
    logic        i_evt_valid;
    logic        o_evt_ready;
    logic        i_evt_note_on;
    logic [6:0]  i_evt_note;
    logic [6:0]  i_evt_velocity;
    logic [31:0] i_evt_tuning_code;
    logic        o_voice_valid;
    logic [7:0]  o_voice_index;
    logic        o_note_status;
    logic [31:0] o_tuning_code;
    logic [6:0]  o_velocity;
    logic        o_flag_dds;
    logic        o_flag_adsr;
    logic        o_steal;
    logic        o_drop;
    logic [6:0]  o_active_count;
    logic [1:0]  o_dbg_state;

    modport slave (
        input  i_evt_valid, i_evt_note_on, i_evt_note, i_evt_velocity, i_evt_tuning_code,
        output o_evt_ready, o_voice_valid, o_voice_index, o_note_status, o_tuning_code,
               o_velocity, o_flag_dds, o_flag_adsr, o_steal, o_drop, o_active_count,
               o_dbg_state
    );

    modport master (
        output i_evt_valid, i_evt_note_on, i_evt_note, i_evt_velocity, i_evt_tuning_code,
        input  o_evt_ready, o_voice_valid, o_voice_index, o_note_status, o_tuning_code,
               o_velocity, o_flag_dds, o_flag_adsr, o_steal, o_drop, o_active_count,
               o_dbg_state
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. Each accepted note event is mapped to a voice
// slot (same-note retrigger, lowest free voice, or oldest-voice steal) by a
// serial scan of the voice table, then one update strobe is issued.
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset
//   bus     - voice_allocator_if.slave (event in, voice update out, debug)
// Timing: accept at cycle 0, voice k examined at cycle k+1, strobe or drop
// at cycle NUM_VOICES+1, ready again at cycle NUM_VOICES+2.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all
// voices are busy; otherwise such a note-on is dropped and o_steal stays 0.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    voice_allocator_if.slave  bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_ISSUE = 2'd2} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Registered event; evt_on is already cleared for velocity-0 note-ons.
    logic        evt_on_q, evt_on_d;
    logic [6:0]  evt_note_q, evt_note_d;
    logic [6:0]  evt_vel_q, evt_vel_d;
    logic [31:0] evt_tun_q, evt_tun_d;

    // Voice table.
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_d  [NUM_VOICES];

    // Scan accumulators.
    logic             match_found_q, match_found_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_found_q, free_found_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             old_found_q, old_found_d;
    logic [IDX_W-1:0] old_idx_q, old_idx_d;
    logic [AGE_W-1:0] old_age_q, old_age_d;

    // Decision made on the last scan cycle, applied to the table in ISSUE.
    logic [IDX_W-1:0] target_q, target_d;

    // Output registers.
    logic        voice_valid_q, voice_valid_d;
    logic [7:0]  index_q, index_d;
    logic        status_q, status_d;
    logic [31:0] tuning_q, tuning_d;
    logic [6:0]  velocity_q, velocity_d;
    logic        dds_q, dds_d;
    logic        adsr_q, adsr_d;
    logic        steal_q, steal_d;
    logic        drop_q, drop_d;
    logic [6:0]  count_q, count_d;

    logic evt_ready;
    assign evt_ready = (state_q == ST_IDLE) && !i_reset;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        evt_on_d      = evt_on_q;
        evt_note_d    = evt_note_q;
        evt_vel_d     = evt_vel_q;
        evt_tun_d     = evt_tun_q;
        active_d      = active_q;
        note_d        = note_q;
        age_d         = age_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_found_d   = old_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        target_d      = target_q;
        voice_valid_d = 1'b0;
        index_d       = index_q;
        status_d      = status_q;
        tuning_d      = tuning_q;
        velocity_d    = velocity_q;
        dds_d         = dds_q;
        adsr_d        = adsr_q;
        steal_d       = 1'b0;
        drop_d        = 1'b0;

        // Fold voice cnt_q into the scan results. Strict '>' keeps the
        // lowest index on age ties because lower indices are seen first.
        if (state_q == ST_SCAN) begin
            if (active_q[cnt_q]) begin
                if (!match_found_q && note_q[cnt_q] == evt_note_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = cnt_q;
                end
                if (!old_found_q || age_q[cnt_q] > old_age_q) begin
                    old_found_d = 1'b1;
                    old_idx_d   = cnt_q;
                    old_age_d   = age_q[cnt_q];
                end
            end else if (!free_found_q) begin
                free_found_d = 1'b1;
                free_idx_d   = cnt_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_evt_valid && evt_ready) begin
                    evt_on_d      = bus.i_evt_note_on && (bus.i_evt_velocity != 7'd0);
                    evt_note_d    = bus.i_evt_note;
                    evt_vel_d     = bus.i_evt_velocity;
                    evt_tun_d     = bus.i_evt_tuning_code;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    old_found_d   = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_ISSUE;
                    if (evt_on_d) begin
                        if (match_found_d) begin
                            target_d      = match_idx_d;
                            voice_valid_d = 1'b1;
                        end else if (free_found_d) begin
                            target_d      = free_idx_d;
                            voice_valid_d = 1'b1;
                        end else begin
`ifdef VOICE_STEAL_EN
                            target_d      = old_idx_d;
                            voice_valid_d = 1'b1;
                            steal_d       = 1'b1;
`else
                            drop_d        = 1'b1;
`endif
                        end
                    end else if (match_found_d) begin
                        target_d      = match_idx_d;
                        voice_valid_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                    if (voice_valid_d) begin
                        index_d    = 8'(target_d);
                        status_d   = evt_on_q;
                        dds_d      = evt_on_q;
                        adsr_d     = 1'b1;
                        velocity_d = evt_on_q ? evt_vel_q : 7'd0;
                        if (evt_on_q) tuning_d = evt_tun_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
                if (voice_valid_q) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == target_q) begin
                            active_d[v] = evt_on_q;
                            age_d[v]    = '0;
                            if (evt_on_q) note_d[v] = evt_note_q;
                        end else if (evt_on_q && active_q[v] && age_q[v] != AGE_MAX) begin
                            age_d[v] = age_q[v] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        count_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) count_d = count_d + 7'(active_d[v]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            evt_on_q      <= 1'b0;
            evt_note_q    <= '0;
            evt_vel_q     <= '0;
            evt_tun_q     <= '0;
            active_q      <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                age_q[v]  <= '0;
            end
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_found_q   <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            target_q      <= '0;
            voice_valid_q <= 1'b0;
            index_q       <= '0;
            status_q      <= 1'b0;
            tuning_q      <= '0;
            velocity_q    <= '0;
            dds_q         <= 1'b0;
            adsr_q        <= 1'b0;
            steal_q       <= 1'b0;
            drop_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            evt_on_q      <= evt_on_d;
            evt_note_q    <= evt_note_d;
            evt_vel_q     <= evt_vel_d;
            evt_tun_q     <= evt_tun_d;
            active_q      <= active_d;
            note_q        <= note_d;
            age_q         <= age_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_found_q   <= old_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            target_q      <= target_d;
            voice_valid_q <= voice_valid_d;
            index_q       <= index_d;
            status_q      <= status_d;
            tuning_q      <= tuning_d;
            velocity_q    <= velocity_d;
            dds_q         <= dds_d;
            adsr_q        <= adsr_d;
            steal_q       <= steal_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
        end
    end

    assign bus.o_evt_ready    = evt_ready;
    assign bus.o_voice_valid  = voice_valid_q;
    assign bus.o_voice_index  = index_q;
    assign bus.o_note_status  = status_q;
    assign bus.o_tuning_code  = tuning_q;
    assign bus.o_velocity     = velocity_q;
    assign bus.o_flag_dds     = dds_q;
    assign bus.o_flag_adsr    = adsr_q;
    assign bus.o_steal        = steal_q;
    assign bus.o_drop         = drop_q;
    assign bus.o_active_count = count_q;
    assign bus.o_dbg_state    = state_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator (NUM_VOICES=8, AGE_W=8).
module tb_voice_allocator;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    voice_allocator_if bus();

    voice_allocator #(.NUM_VOICES(8), .AGE_W(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Results of the most recent event.
    int          r_lat;
    logic        r_valid, r_status, r_dds, r_adsr, r_steal, r_drop;
    logic [7:0]  r_idx;
    logic [6:0]  r_vel;
    logic [31:0] r_tun;
    logic        r_ready_after, r_valid_after;
    logic [6:0]  r_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_evt_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Drive one event at a negedge and return at the negedge of cycle 1.
    task automatic accept_event(input logic on, input logic [6:0] note,
                                input logic [6:0] vel, input logic [31:0] tun);
        int i;
        @(negedge clk);
        i = 0;
        while (!bus.o_evt_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!bus.o_evt_ready) check("ready_wait", 64'(bus.o_evt_ready), 64'd1);
        bus.i_evt_valid       = 1'b1;
        bus.i_evt_note_on     = on;
        bus.i_evt_note        = note;
        bus.i_evt_velocity    = vel;
        bus.i_evt_tuning_code = tun;
        @(posedge clk);
        @(negedge clk);
        // Junk on the inputs while busy must be ignored.
        bus.i_evt_valid       = 1'(($urandom_range(0, 1)));
        bus.i_evt_note_on     = 1'($urandom_range(0, 1));
        bus.i_evt_note        = 7'($urandom_range(0, 127));
        bus.i_evt_velocity    = 7'($urandom_range(1, 127));
        bus.i_evt_tuning_code = $urandom;
    endtask

    task automatic do_event(input logic on, input logic [6:0] note,
                            input logic [6:0] vel, input logic [31:0] tun);
        int  cyc;
        bit  seen;
        accept_event(on, note, vel, tun);
        cyc  = 1;
        seen = 0;
        while (cyc < 40 && !seen) begin
            if (bus.o_voice_valid || bus.o_drop) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.i_evt_valid = 1'b0;
        r_lat    = cyc;
        r_valid  = bus.o_voice_valid;
        r_idx    = bus.o_voice_index;
        r_status = bus.o_note_status;
        r_dds    = bus.o_flag_dds;
        r_adsr   = bus.o_flag_adsr;
        r_vel    = bus.o_velocity;
        r_tun    = bus.o_tuning_code;
        r_steal  = bus.o_steal;
        r_drop   = bus.o_drop;
        @(negedge clk);
        r_ready_after = bus.o_evt_ready;
        r_valid_after = bus.o_voice_valid;
        r_count       = bus.o_active_count;
    endtask

    task automatic expect_on(input string tag, input logic [7:0] idx, input logic [6:0] vel,
                             input logic [31:0] tun, input logic steal, input logic [6:0] cnt);
        check({tag, "_lat"},    64'(r_lat), 64'd9);
        check({tag, "_valid"},  64'(r_valid), 64'd1);
        check({tag, "_idx"},    64'(r_idx), 64'(idx));
        check({tag, "_status"}, 64'(r_status), 64'd1);
        check({tag, "_flags"},  64'({r_dds, r_adsr}), 64'd3);
        check({tag, "_vel"},    64'(r_vel), 64'(vel));
        check({tag, "_tun"},    64'(r_tun), 64'(tun));
        check({tag, "_steal"},  64'(r_steal), 64'(steal));
        check({tag, "_drop"},   64'(r_drop), 64'd0);
        check({tag, "_count"},  64'(r_count), 64'(cnt));
        check({tag, "_onecyc"}, 64'(r_valid_after), 64'd0);
        check({tag, "_ready"},  64'(r_ready_after), 64'd1);
    endtask

    task automatic expect_drop(input string tag, input logic [6:0] cnt);
        check({tag, "_lat"},   64'(r_lat), 64'd9);
        check({tag, "_valid"}, 64'(r_valid), 64'd0);
        check({tag, "_drop"},  64'(r_drop), 64'd1);
        check({tag, "_steal"}, 64'(r_steal), 64'd0);
        check({tag, "_count"}, 64'(r_count), 64'(cnt));
        check({tag, "_ready"}, 64'(r_ready_after), 64'd1);
    endtask

    initial begin
        int seen_strobe;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.i_evt_valid       = 1'b0;
        bus.i_evt_note_on     = 1'b0;
        bus.i_evt_note        = '0;
        bus.i_evt_velocity    = '0;
        bus.i_evt_tuning_code = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",  64'(bus.o_evt_ready), 64'd0);
        check("rst_outs",   64'({bus.o_voice_valid, bus.o_voice_index, bus.o_note_status,
                                 bus.o_velocity, bus.o_flag_dds, bus.o_flag_adsr,
                                 bus.o_steal, bus.o_drop, bus.o_active_count}), 64'd0);
        check("rst_tun",    64'(bus.o_tuning_code), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_after", 64'(bus.o_evt_ready), 64'd1);

        // First note-on, then a second voice, then a note-off.
        do_event(1'b1, 7'd60, 7'd100, 32'h0001_0000);
        expect_on("on60", 8'd0, 7'd100, 32'h0001_0000, 1'b0, 7'd1);
        do_event(1'b1, 7'd64, 7'd90, 32'h0002_0000);
        expect_on("on64", 8'd1, 7'd90, 32'h0002_0000, 1'b0, 7'd2);
        do_event(1'b0, 7'd60, 7'd55, 32'hDEAD_BEEF);
        check("off60_valid",  64'(r_valid), 64'd1);
        check("off60_idx",    64'(r_idx), 64'd0);
        check("off60_status", 64'(r_status), 64'd0);
        check("off60_flags",  64'({r_dds, r_adsr}), 64'd1);
        check("off60_vel",    64'(r_vel), 64'd0);
        check("off60_tun",    64'(r_tun), 64'h0002_0000);
        check("off60_count",  64'(r_count), 64'd1);

        // Note-off for a note nobody holds.
        do_event(1'b0, 7'd72, 7'd10, 32'h0);
        expect_drop("off72", 7'd1);

        // Freed voice 0 is the lowest free slot again.
        do_event(1'b1, 7'd67, 7'd30, 32'h0003_0000);
        expect_on("on67_free", 8'd0, 7'd30, 32'h0003_0000, 1'b0, 7'd2);

        // Fill all voices, then overflow.
        do_reset();
        for (int n = 0; n < 8; n++) begin
            do_event(1'b1, 7'(60 + n), 7'(10 + n), 32'(n + 1));
            check("fill_idx",   64'(r_idx), 64'(n));
            check("fill_count", 64'(r_count), 64'(n + 1));
        end
`ifdef VOICE_STEAL_EN
        do_event(1'b1, 7'd70, 7'd77, 32'h0007_0000);
        expect_on("steal70", 8'd0, 7'd77, 32'h0007_0000, 1'b1, 7'd8);
        // Voice 1 is now oldest (age 7); voice 0 was reset to age 0.
        do_event(1'b1, 7'd71, 7'd78, 32'h0007_1000);
        expect_on("steal71", 8'd1, 7'd78, 32'h0007_1000, 1'b1, 7'd8);
`else
        do_event(1'b1, 7'd70, 7'd77, 32'h0007_0000);
        expect_drop("full70", 7'd8);
        check("full70_tun_held", 64'(r_tun), 64'd8);
`endif
        // Retrigger of a held note in a full table goes to its own voice.
        do_event(1'b1, 7'd63, 7'd5, 32'h0009_0000);
        expect_on("retrig63", 8'd3, 7'd5, 32'h0009_0000, 1'b0, 7'd8);

        // Same-note retrigger and velocity-0 note-on.
        do_reset();
        do_event(1'b1, 7'd60, 7'd100, 32'h0001_0000);
        expect_on("re60a", 8'd0, 7'd100, 32'h0001_0000, 1'b0, 7'd1);
        do_event(1'b1, 7'd60, 7'd20, 32'h0001_0000);
        expect_on("re60b", 8'd0, 7'd20, 32'h0001_0000, 1'b0, 7'd1);
        do_event(1'b1, 7'd62, 7'd0, 32'h0005_0000);
        expect_drop("vel0_62", 7'd1);

        // Reset during scan cycle 4 discards the event.
        accept_event(1'b1, 7'd64, 7'd50, 32'h0004_0000);
        repeat (3) @(negedge clk);
        check("mid_state", 64'(bus.o_dbg_state), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_evt_valid = 1'b0;
        #1;
        check("mid_ready", 64'(bus.o_evt_ready), 64'd1);
        check("mid_count", 64'(bus.o_active_count), 64'd0);
        seen_strobe = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.o_voice_valid || bus.o_drop) seen_strobe++;
        end
        check("mid_no_strobe", 64'(seen_strobe), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
